// File: rtl/slave_mem_loader_pkg.sv
// Shared states and helpers for the slave RAM preloader.
// Read-back check is built in with SLAVE_MEM_LOADER_READBACK_EN.
package slave_mem_loader_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FILL   = 3'd1;
  localparam logic [2:0] ST_WRITE  = 3'd2;
  localparam logic [2:0] ST_VERIFY = 3'd3;
  localparam logic [2:0] ST_START  = 3'd4;
  localparam logic [2:0] ST_RUN    = 3'd5;
  localparam logic [2:0] ST_ERR    = 3'd6;

  // Size field is in bits, not bytes.
  function automatic logic [15:0] bytes_to_size(
    input logic [3:0] nb
  );
    return {9'd0, nb, 3'b000};
  endfunction

  function automatic logic [1:0] ch0_bit(
    input logic b
  );
    return {1'b0, b};
  endfunction

  function automatic logic ch0_rdy(
    input logic [1:0] r
  );
    return r[0];
  endfunction

endpackage

// File: rtl/slave_mem_loader_if.sv
// Two-channel slave RAM port of the HLS top.
// Master drives requests, slave returns data/ready.
interface slave_mem_loader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64,
  parameter int SIZE_W = 7
);

  logic [1:0]          S_oe_ram;
  logic [1:0]          S_we_ram;
  logic [2*ADDR_W-1:0] S_addr_ram;
  logic [2*DATA_W-1:0] S_Wdata_ram;
  logic [2*SIZE_W-1:0] S_data_ram_size;
  logic [2*DATA_W-1:0] Sout_Rdata_ram;
  logic [1:0]          Sout_DataRdy;

  modport master (
    output S_oe_ram,
    output S_we_ram,
    output S_addr_ram,
    output S_Wdata_ram,
    output S_data_ram_size,
    input  Sout_Rdata_ram,
    input  Sout_DataRdy
  );

  modport slave (
    input  S_oe_ram,
    input  S_we_ram,
    input  S_addr_ram,
    input  S_Wdata_ram,
    input  S_data_ram_size,
    output Sout_Rdata_ram,
    output Sout_DataRdy
  );

endinterface

// File: rtl/slave_mem_loader_byte_word_packer.sv
// Packs a byte stream little-endian into slave-width words.
// seal fires on the byte that fills the word or ends the load.
module byte_word_packer #(
  parameter int WORD_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    byte_valid,
  input  logic [7:0]              byte_data,
  input  logic                    clear,
  input  logic [15:0]             remaining,
  output logic                    byte_ready,
  output logic [8*WORD_BYTES-1:0] word,
  output logic [3:0]              cnt,
  output logic                    last,
  output logic                    seal
);

  logic [8*WORD_BYTES-1:0] word_q, word_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [3:0]              cnt_inc;
  logic                    accept;
  logic                    word_full;
  logic                    last_in;

  assign byte_ready = en;
  assign accept     = en & byte_valid;
  assign cnt_inc    = cnt_q + 4'd1;
  assign word_full  = cnt_inc == 4'(WORD_BYTES);
  assign last_in    = {12'h0, cnt_inc} == remaining;
  assign seal       = accept & (word_full | last_in);
  assign last       = (cnt_q != 4'd0) &&
                      ({12'h0, cnt_q} == remaining);
  assign word       = word_q;
  assign cnt        = cnt_q;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (accept) begin
      for (int k = 0; k < WORD_BYTES; k++) begin
        if (cnt_q == 4'(k)) word_d[8*k +: 8] = byte_data;
      end
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/slave_mem_loader.sv
// Preloads main's memory over slave channel 0, starts it, times it.
// Define SLAVE_MEM_LOADER_READBACK_EN to read back every write.
module slave_mem_loader
  import slave_mem_loader_pkg::*;
#(
  parameter int MEM_BASE   = 256,
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 64,
  parameter int SIZE_W     = 7,
  parameter int WORD_BYTES = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cfg_valid,
  input  logic [15:0] cfg_nbytes,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  slave_mem_loader_if.master sbus,
  output logic        start_port,
  input  logic        done_port,
  output logic        busy,
  output logic        load_done,
  output logic        timeout_err,
  output logic [31:0] sim_cycles
`ifdef SLAVE_MEM_LOADER_READBACK_EN
  ,
  output logic        verify_err
`endif
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [2:0]      state_q, state_d;
  logic [15:0]     rem_q, rem_d;
  logic [15:0]     off_q, off_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [31:0]     sim_q, sim_d;
  logic            ld_q, ld_d;
  logic            to_q, to_d;
  logic            commit;
  logic            wd_hit;
  logic            rdy0;
  logic            acc;
  logic            unused_in;

  logic [8*WORD_BYTES-1:0] pk_word;
  logic [3:0]              pk_cnt;
  logic                    pk_last;
  logic                    pk_seal;
  logic                    pk_clear;

  byte_word_packer #(
    .WORD_BYTES (WORD_BYTES)
  ) u_packer (
    .clk        (clock),
    .rst_n      (reset),
    .en         (state_q == ST_FILL),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .clear      (pk_clear),
    .remaining  (rem_q),
    .byte_ready (byte_ready),
    .word       (pk_word),
    .cnt        (pk_cnt),
    .last       (pk_last),
    .seal       (pk_seal)
  );

  assign rdy0      = ch0_rdy(sbus.Sout_DataRdy);
  assign wd_hit    = wd_q == WD_W'(TIMEOUT - 1);
  assign unused_in = ^{sbus.Sout_Rdata_ram, sbus.Sout_DataRdy};

`ifdef SLAVE_MEM_LOADER_READBACK_EN
  logic              verr_q, verr_d;
  logic [DATA_W-1:0] rd_mask;
  logic              rd_bad;

  always_comb begin
    rd_mask = '0;
    for (int k = 0; k < WORD_BYTES; k++) begin
      if (4'(k) < pk_cnt) rd_mask[8*k +: 8] = 8'hFF;
    end
  end

  assign rd_bad = (sbus.Sout_Rdata_ram[DATA_W-1:0] & rd_mask)
                  != DATA_W'(pk_word);
  assign verify_err = verr_q;
`endif

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    off_d    = off_q;
    wd_d     = '0;
    sim_d    = sim_q;
    ld_d     = 1'b0;
    to_d     = to_q;
    commit   = 1'b0;
    pk_clear = 1'b0;
`ifdef SLAVE_MEM_LOADER_READBACK_EN
    verr_d   = verr_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          rem_d = cfg_nbytes;
          off_d = '0;
          if (cfg_nbytes == 16'd0) begin
            state_d = ST_START;
            sim_d   = 32'd1;
          end else begin
            state_d = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        if (pk_seal) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (rdy0) begin
`ifdef SLAVE_MEM_LOADER_READBACK_EN
          state_d = ST_VERIFY;
`else
          commit = 1'b1;
`endif
        end else if (wd_hit) begin
          to_d    = 1'b1;
          state_d = ST_ERR;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
`ifdef SLAVE_MEM_LOADER_READBACK_EN
      ST_VERIFY: begin
        if (rdy0) begin
          if (rd_bad) verr_d = 1'b1;
          commit = 1'b1;
        end else if (wd_hit) begin
          to_d    = 1'b1;
          state_d = ST_ERR;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
`endif
      ST_START: begin
        // done in the start cycle itself counts as one cycle
        if (done_port) begin
          ld_d    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
          sim_d   = sim_q + 32'd1;
        end
      end
      ST_RUN: begin
        if (done_port) begin
          ld_d    = 1'b1;
          state_d = ST_IDLE;
        end else if (wd_hit) begin
          to_d    = 1'b1;
          state_d = ST_ERR;
        end else begin
          wd_d = wd_q + WD_W'(1);
          if (sim_q != '1) sim_d = sim_q + 32'd1;
        end
      end
      ST_ERR: begin
      end
      default: state_d = ST_IDLE;
    endcase

    if (commit) begin
      off_d    = off_q + {12'h0, pk_cnt};
      rem_d    = rem_q - {12'h0, pk_cnt};
      pk_clear = 1'b1;
      if (pk_last) begin
        state_d = ST_START;
        sim_d   = 32'd1;
      end else begin
        state_d = ST_FILL;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      off_q   <= '0;
      wd_q    <= '0;
      sim_q   <= '0;
      ld_q    <= 1'b0;
      to_q    <= 1'b0;
`ifdef SLAVE_MEM_LOADER_READBACK_EN
      verr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      off_q   <= off_d;
      wd_q    <= wd_d;
      sim_q   <= sim_d;
      ld_q    <= ld_d;
      to_q    <= to_d;
`ifdef SLAVE_MEM_LOADER_READBACK_EN
      verr_q  <= verr_d;
`endif
    end
  end

  // Bus fields are driven only while an access is in flight.
  assign acc = (state_q == ST_WRITE) || (state_q == ST_VERIFY);

  assign sbus.S_we_ram = ch0_bit(state_q == ST_WRITE);
`ifdef SLAVE_MEM_LOADER_READBACK_EN
  assign sbus.S_oe_ram = ch0_bit(state_q == ST_VERIFY);
`else
  assign sbus.S_oe_ram = 2'b00;
`endif

  assign sbus.S_addr_ram = {
    {ADDR_W{1'b0}},
    acc ? ADDR_W'(32'(MEM_BASE) + {16'h0, off_q})
        : {ADDR_W{1'b0}}
  };
  assign sbus.S_Wdata_ram = {
    {DATA_W{1'b0}},
    acc ? DATA_W'(pk_word) : {DATA_W{1'b0}}
  };
  assign sbus.S_data_ram_size = {
    {SIZE_W{1'b0}},
    acc ? SIZE_W'(bytes_to_size(pk_cnt))
        : {SIZE_W{1'b0}}
  };

  assign start_port  = state_q == ST_START;
  assign busy        = state_q != ST_IDLE;
  assign load_done   = ld_q;
  assign timeout_err = to_q;
  assign sim_cycles  = sim_q;

endmodule
